// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB PWM generator: default width, channel indices
// and the gamma (square-law) mapping used when RGB_PWM_GAMMA_EN is defined.
package rgb_pwm_pkg;

    localparam int PWM_WIDTH_DEF = 12;
    localparam int NUM_CH        = 3;
    localparam int CH_R          = 0;
    localparam int CH_G          = 1;
    localparam int CH_B          = 2;

    // Square at full double width before shifting so no product bits are lost.
    function automatic logic [31:0] gamma(input logic [31:0] d, input int unsigned w);
        logic [63:0] sq;
        logic [63:0] sh;
        sq = 64'(d) * 64'(d);
        sh = sq >> w;
        return sh[31:0];
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: active duty register, counter compare and output flop.
// RGB_PWM_GAMMA_EN selects square-law mapping of the duty on load.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_WIDTH = PWM_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic [PWM_WIDTH-1:0] i_shadow,
    input  logic [PWM_WIDTH-1:0] i_pwm_ctr,
    output logic                 o_pwm
);

    logic [PWM_WIDTH-1:0] r_active;
    logic                 r_pwm;
    logic [PWM_WIDTH-1:0] w_load_val;

`ifdef RGB_PWM_GAMMA_EN
    assign w_load_val = PWM_WIDTH'(gamma(32'(i_shadow), PWM_WIDTH));
`else
    assign w_load_val = i_shadow;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_load) begin
                r_active <= w_load_val;
            end
            r_pwm <= i_en & (i_pwm_ctr < r_active);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator with prescaler, shadowed duty handshake and
// wrap-aligned duty update. Optional macro: RGB_PWM_GAMMA_EN (gamma on load).
module rgb_pwm_gen
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_WIDTH = PWM_WIDTH_DEF,
    parameter int PRESCALE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PWM_WIDTH-1:0] in_r,
    input  logic [PWM_WIDTH-1:0] in_g,
    input  logic [PWM_WIDTH-1:0] in_b,
    output logic                 pwm_r,
    output logic                 pwm_g,
    output logic                 pwm_b,
    output logic                 period_done
);

    localparam int                   PRE_W    = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE);
    localparam logic [PWM_WIDTH-1:0] CTR_LAST = '1;

    logic [PRE_W-1:0]     r_pre_ctr;
    logic [PWM_WIDTH-1:0] r_pwm_ctr;
    logic                 r_period_done;
    logic                 r_pending;
    logic [PWM_WIDTH-1:0] r_shadow [NUM_CH];

    logic [PWM_WIDTH-1:0] w_in [NUM_CH];
    logic [NUM_CH-1:0]    w_pwm;
    logic                 w_step;
    logic                 w_wrap;
    logic                 w_xfer;
    logic                 w_load;

    assign w_in[CH_R] = in_r;
    assign w_in[CH_G] = in_g;
    assign w_in[CH_B] = in_b;

    assign w_step = en & (r_pre_ctr == PRE_LAST);
    assign w_wrap = w_step & (r_pwm_ctr == CTR_LAST);
    assign w_xfer = in_valid & ~r_pending;
    // While disabled there is no wrap to wait for, so a pending duty loads at once.
    assign w_load = r_pending & (w_wrap | ~en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_ctr     <= '0;
            r_pwm_ctr     <= '0;
            r_period_done <= 1'b0;
        end else begin
            if (!en) begin
                r_pre_ctr <= '0;
                r_pwm_ctr <= '0;
            end else begin
                r_pre_ctr <= w_step ? '0 : r_pre_ctr + 1'b1;
                if (w_step) begin
                    r_pwm_ctr <= r_pwm_ctr + 1'b1;
                end
            end
            r_period_done <= w_wrap;
        end
    end

    // A transfer on the wrap cycle only sets pending; it is applied one wrap later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_xfer) begin
            r_pending <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= w_in[i];
            end
        end else if (w_load) begin
            r_pending <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_WIDTH(PWM_WIDTH)
        ) u_ch (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_en     (en),
            .i_load   (w_load),
            .i_shadow (r_shadow[i]),
            .i_pwm_ctr(r_pwm_ctr),
            .o_pwm    (w_pwm[i])
        );
    end

    assign in_ready    = ~r_pending;
    assign pwm_r       = w_pwm[CH_R];
    assign pwm_g       = w_pwm[CH_G];
    assign pwm_b       = w_pwm[CH_B];
    assign period_done = r_period_done;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Scoreboard bench for rgb_pwm_gen: period-level model of duty updates,
// plus a PRESCALE=3 instance for period length and async reset behaviour.
module tb_rgb_pwm_gen;

    localparam int W   = 12;
    localparam int N   = 1 << W;
    localparam int NC3 = N * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, in_valid, in_ready;
    logic [W-1:0] in_r, in_g, in_b;
    logic         pwm_r, pwm_g, pwm_b, period_done;

    logic         rst3, en3, in_valid3, in_ready3;
    logic [W-1:0] in_r3, in_g3, in_b3;
    logic         pwm_r3, pwm_g3, pwm_b3, pd3;

    rgb_pwm_gen #(.PWM_WIDTH(W), .PRESCALE(0)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .period_done(period_done)
    );

    rgb_pwm_gen #(.PWM_WIDTH(W), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_r(in_r3), .in_g(in_g3), .in_b(in_b3),
        .pwm_r(pwm_r3), .pwm_g(pwm_g3), .pwm_b(pwm_b3), .period_done(pd3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int p;
        int r;
        int g;
        int b;
    } upd_t;

    upd_t sbq[$];
    int   m_duty[3] = '{0, 0, 0};
    int   acc[3]    = '{0, 0, 0};
    int   cyc       = 0;
    int   ecount    = 0;
    logic en_last   = 1'b0;
    int   clear_cyc = 0;
    logic done3     = 1'b0;

    function automatic int hi_steps(int d);
`ifdef RGB_PWM_GAMMA_EN
        return (d * d) >> W;
`else
        return d;
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ecount = number of consecutive enabled edges; the period index follows from it.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_last <= rst ? 1'b0 : en;
        ecount  <= (rst || !en) ? 0 : ecount + 1;
    end

    // Monitor: output window of period p is the samples after edges p*N+1 .. (p+1)*N.
    always @(negedge clk) begin
        upd_t u;
        int   p;
        if (rst) begin
            acc = '{0, 0, 0};
        end else if (!en_last) begin
            check("idle_outputs", int'({pwm_r, pwm_g, pwm_b, period_done}), 0);
            acc = '{0, 0, 0};
            while (sbq.size() > 0) begin
                u = sbq.pop_front();
                m_duty = '{u.r, u.g, u.b};
            end
        end else begin
            acc[0] += int'(pwm_r);
            acc[1] += int'(pwm_g);
            acc[2] += int'(pwm_b);
            check("period_done", int'(period_done), int'(ecount % N == 0));
            if (ecount % N == 0) begin
                p = ecount / N - 1;
                while (sbq.size() > 0 && sbq[0].p <= p) begin
                    u = sbq.pop_front();
                    m_duty = '{u.r, u.g, u.b};
                end
                check("high_r", acc[0], hi_steps(m_duty[0]));
                check("high_g", acc[1], hi_steps(m_duty[1]));
                check("high_b", acc[2], hi_steps(m_duty[2]));
                acc = '{0, 0, 0};
            end
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_mod(int m);
        int guard = 0;
        while (ecount % N != m) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2 * N) begin
                check("wait_mod_timeout", guard, 0);
                break;
            end
        end
    endtask

    // Called #1 after an edge. Expected ready comes from the model's clear time.
    task automatic send(int r, int g, int b);
        int   waited = 0;
        int   s;
        int   p;
        upd_t u;
        in_r     = W'(r);
        in_g     = W'(g);
        in_b     = W'(b);
        in_valid = 1'b1;
        forever begin
            check("in_ready", int'(in_ready), int'(cyc >= clear_cyc));
            if (in_ready) break;
            if (waited > 3 * N) begin
                check("send_timeout", waited, 0);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s = ecount;
        if (en) begin
            p = s / N + 1;
            clear_cyc = cyc + (p * N - s);
        end else begin
            p = 0;
            clear_cyc = cyc + 1;
        end
        u.p = p; u.r = r; u.g = g; u.b = b;
        sbq.push_back(u);
    endtask

    function automatic int rnd_duty();
        int sel = $urandom_range(0, 5);
        if (sel == 0) return 0;
        if (sel == 1) return N - 1;
        return $urandom_range(0, N - 1);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_outputs", int'({pwm_r, pwm_g, pwm_b, period_done}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;

        // no input: outputs stay low, period_done every N cycles
        wait_cycles(2 * N + 10);

        // boundary duties
        send(1024, 0, N - 1);
        wait_cycles(2 * N + 4);

        // back-to-back: second stalls until after the wrap
        send(rnd_duty(), rnd_duty(), rnd_duty());
        send(rnd_duty(), rnd_duty(), rnd_duty());
        wait_cycles(2 * N + 4);

        // transfer on the wrap edge: old duty persists one more period
        wait_mod(N - 1);
        send(rnd_duty(), rnd_duty(), rnd_duty());
        wait_cycles(2 * N + 4);

        repeat (2) begin
            wait_cycles($urandom_range(1, N / 2));
            send(rnd_duty(), rnd_duty(), rnd_duty());
        end
        wait_cycles(2 * N + 4);

        // disabled: pending loads immediately, new duty in effect on enable
        en = 1'b0;
        wait_cycles(2);
        send(2048, 3000, 17);
        wait_cycles(3);
        en = 1'b1;
        wait_cycles(N + 4);

        check("sb_empty", sbq.size(), 0);
        wait (done3 == 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int hi_r;
        int hi_g;
        int pd_pos;
        rst3 = 1'b1; en3 = 1'b0; in_valid3 = 1'b0;
        in_r3 = '0; in_g3 = '0; in_b3 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst3 = 1'b0;
        @(posedge clk);
        #1;
        in_r3 = W'(2048);
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        check("p3_pending", int'(in_ready3), 0);
        @(posedge clk);
        #1;
        check("p3_load_while_off", int'(in_ready3), 1);
        en3 = 1'b1;

        hi_r = 0; hi_g = 0; pd_pos = -1;
        for (int k = 1; k <= NC3; k++) begin
            @(posedge clk);
            @(negedge clk);
            hi_r += int'(pwm_r3);
            hi_g += int'(pwm_g3);
            if (pd3 && pd_pos < 0) pd_pos = k;
        end
        check("p3_period_len", pd_pos, NC3);
        check("p3_high_r", hi_r, hi_steps(2048) * 4);
        check("p3_high_g", hi_g, 0);

        // mid-period reset with a value pending
        wait_cycles(3000);
        in_r3 = W'(100);
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        check("p3_pending2", int'(in_ready3), 0);
        wait_cycles(2);
        check("p3_pre_rst_pwm", int'(pwm_r3), 1);
        #2;
        rst3 = 1'b1;
        #1;
        check("p3_rst_outputs", int'({pwm_r3, pwm_g3, pwm_b3, pd3}), 0);
        check("p3_rst_ready", int'(in_ready3), 1);
        done3 = 1'b1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
